// File: rtl/uart_msg_pkg.sv
// Shared definitions for the UART message engine: byte width and the
// transmit-side state encoding used by uart_byte_serializer.
package uart_msg_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_ISSUE = 2'd1,
        TX_START = 2'd2,
        TX_DRAIN = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_msg_engine_if.sv
// Byte-level link between the message engine and the uart serial module.
// master = message engine, slave = uart.
interface uart_msg_engine_if;

    logic [7:0] rx_data;
    logic       rx_strobe;
    logic       rx_error;
    logic       rx_active;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_strobe;

    modport master (
        input  rx_data, rx_strobe, rx_error, rx_active, tx_busy,
        output tx_data, tx_strobe
    );

    modport slave (
        output rx_data, rx_strobe, rx_error, rx_active, tx_busy,
        input  tx_data, tx_strobe
    );

endinterface

// File: rtl/uart_byte_serializer.sv
// Sends the nonce register MSB byte first, one byte per uart transmission,
// handshaking on tx_busy and holding off while the uart is receiving.
// Optional feature: UART_MSG_CHECKSUM_EN appends an XOR-of-all-bytes trailer.
module uart_byte_serializer
    import uart_msg_pkg::*;
#(
    parameter int NONCE_BYTES = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NONCE_BYTES*BYTE_W-1:0] nonce_in,
    input  logic                          nonce_we,
    input  logic                          send_req,
    input  logic                          tx_busy,
    input  logic                          rx_active,
    output logic [BYTE_W-1:0]             tx_data,
    output logic                          tx_strobe,
    output logic                          tx_done,
    output logic                          tx_active
);

`ifdef UART_MSG_CHECKSUM_EN
    localparam int FRAME_BYTES = NONCE_BYTES + 1;
`else
    localparam int FRAME_BYTES = NONCE_BYTES;
`endif
    localparam int NW = NONCE_BYTES * BYTE_W;
    localparam int SW = FRAME_BYTES * BYTE_W;
    localparam int IW = $clog2(FRAME_BYTES + 1);

`ifdef UART_MSG_CHECKSUM_EN
    // XOR of every byte of the nonce word.
    function automatic logic [BYTE_W-1:0] xor_fold(input logic [NW-1:0] word);
        logic [BYTE_W-1:0] acc;
        acc = {BYTE_W{1'b0}};
        for (int i = 0; i < NONCE_BYTES; i++) begin
            acc = acc ^ word[i*BYTE_W +: BYTE_W];
        end
        return acc;
    endfunction
`endif

    tx_state_e         state_r, state_s;
    logic [NW-1:0]     nonce_r;
    logic [SW-1:0]     shadow_r;
    logic [IW-1:0]     idx_r;
    logic [BYTE_W-1:0] tx_data_r;
    logic              tx_strobe_r, tx_done_r, tx_active_r;
    logic              load_s, issue_s, advance_s, finish_s;
    logic [NW-1:0]     src_s;
    logic [SW-1:0]     frame_s;

    // A nonce written in the same cycle as send_req is the one that goes out.
    assign src_s = nonce_we ? nonce_in : nonce_r;
`ifdef UART_MSG_CHECKSUM_EN
    assign frame_s = {src_s, xor_fold(src_s)};
`else
    assign frame_s = src_s;
`endif

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= TX_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and per-cycle control decisions.
    always_comb begin
        state_s   = state_r;
        load_s    = 1'b0;
        issue_s   = 1'b0;
        advance_s = 1'b0;
        finish_s  = 1'b0;
        case (state_r)
            TX_IDLE: begin
                if (send_req) begin
                    load_s  = 1'b1;
                    state_s = TX_ISSUE;
                end else begin
                    state_s = TX_IDLE;
                end
            end
            TX_ISSUE: begin
                if (!tx_busy && !rx_active) begin
                    issue_s = 1'b1;
                    state_s = TX_START;
                end else begin
                    state_s = TX_ISSUE;
                end
            end
            TX_START: begin
                if (tx_busy) begin
                    state_s = TX_DRAIN;
                end else begin
                    state_s = TX_START;
                end
            end
            TX_DRAIN: begin
                if (!tx_busy) begin
                    advance_s = 1'b1;
                    if (idx_r == IW'(1)) begin
                        finish_s = 1'b1;
                        state_s  = TX_IDLE;
                    end else begin
                        state_s  = TX_ISSUE;
                    end
                end else begin
                    state_s = TX_DRAIN;
                end
            end
            default: begin
                state_s = TX_IDLE;
            end
        endcase
    end

    // Nonce register, shadow copy, byte counter and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            nonce_r     <= {NW{1'b0}};
            shadow_r    <= {SW{1'b0}};
            idx_r       <= {IW{1'b0}};
            tx_data_r   <= {BYTE_W{1'b0}};
            tx_strobe_r <= 1'b0;
            tx_done_r   <= 1'b0;
            tx_active_r <= 1'b0;
        end else begin
            tx_strobe_r <= issue_s;
            tx_done_r   <= finish_s;
            if (nonce_we) begin
                nonce_r <= nonce_in;
            end
            if (load_s) begin
                shadow_r    <= frame_s;
                idx_r       <= IW'(FRAME_BYTES);
                tx_active_r <= 1'b1;
            end else if (advance_s) begin
                shadow_r <= shadow_r << BYTE_W;
                idx_r    <= idx_r - IW'(1);
            end
            if (issue_s) begin
                tx_data_r <= shadow_r[SW-1 -: BYTE_W];
            end
            if (finish_s) begin
                tx_active_r <= 1'b0;
            end
        end
    end

    assign tx_data   = tx_data_r;
    assign tx_strobe = tx_strobe_r;
    assign tx_done   = tx_done_r;
    assign tx_active = tx_active_r;

endmodule

// File: rtl/uart_msg_engine.sv
// Message layer between the uart and the miner core: assembles HDR_BYTES
// received bytes into a header word (with error and inter-byte timeout
// dropping) and serialises the nonce back out via uart_byte_serializer.
// Optional feature: UART_MSG_CHECKSUM_EN adds an XOR trailer byte to each
// received frame and each transmitted nonce.
module uart_msg_engine
    import uart_msg_pkg::*;
#(
    parameter int HDR_BYTES      = 80,
    parameter int NONCE_BYTES    = 4,
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic                          clock,
    input  logic                          reset,
    uart_msg_engine_if.master             uart,
    output logic [HDR_BYTES*BYTE_W-1:0]   header,
    output logic                          header_valid,
    output logic                          frame_err,
    input  logic [NONCE_BYTES*BYTE_W-1:0] nonce_in,
    input  logic                          nonce_we,
    input  logic                          send_req,
    output logic                          tx_done,
    output logic                          tx_active
);

`ifdef UART_MSG_CHECKSUM_EN
    localparam int RX_FRAME = HDR_BYTES + 1;
`else
    localparam int RX_FRAME = HDR_BYTES;
`endif
    localparam int HW = HDR_BYTES * BYTE_W;
    localparam int CW = $clog2(RX_FRAME + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [HW-1:0]     header_r;
    logic [CW-1:0]     rx_cnt_r;
    logic [TW-1:0]     timer_r;
    logic              header_valid_r, frame_err_r;
    logic              last_byte_s, timeout_s;
`ifdef UART_MSG_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_r;
`endif

    assign last_byte_s = (rx_cnt_r == CW'(RX_FRAME - 1));
    assign timeout_s   = (rx_cnt_r != {CW{1'b0}}) && (timer_r == TW'(TIMEOUT_CYCLES - 1));

    // Frame assembly: byte shifting, frame completion, error and timeout drops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            header_r       <= {HW{1'b0}};
            rx_cnt_r       <= {CW{1'b0}};
            timer_r        <= {TW{1'b0}};
            header_valid_r <= 1'b0;
            frame_err_r    <= 1'b0;
`ifdef UART_MSG_CHECKSUM_EN
            csum_r         <= {BYTE_W{1'b0}};
`endif
        end else begin
            header_valid_r <= 1'b0;
            frame_err_r    <= 1'b0;
            if (uart.rx_error) begin
                // A framing error discards any byte strobed alongside it.
                rx_cnt_r    <= {CW{1'b0}};
                timer_r     <= {TW{1'b0}};
                frame_err_r <= 1'b1;
            end else if (uart.rx_strobe) begin
                timer_r <= {TW{1'b0}};
`ifdef UART_MSG_CHECKSUM_EN
                if (last_byte_s) begin
                    // Trailer byte is compared, never shifted into the header.
                    rx_cnt_r <= {CW{1'b0}};
                    if (uart.rx_data == csum_r) begin
                        header_valid_r <= 1'b1;
                    end else begin
                        frame_err_r <= 1'b1;
                    end
                end else begin
                    header_r <= {header_r[HW-BYTE_W-1:0], uart.rx_data};
                    csum_r   <= (rx_cnt_r == {CW{1'b0}}) ? uart.rx_data : (csum_r ^ uart.rx_data);
                    rx_cnt_r <= rx_cnt_r + CW'(1);
                end
`else
                header_r <= {header_r[HW-BYTE_W-1:0], uart.rx_data};
                if (last_byte_s) begin
                    rx_cnt_r       <= {CW{1'b0}};
                    header_valid_r <= 1'b1;
                end else begin
                    rx_cnt_r <= rx_cnt_r + CW'(1);
                end
`endif
            end else if (timeout_s) begin
                rx_cnt_r    <= {CW{1'b0}};
                timer_r     <= {TW{1'b0}};
                frame_err_r <= 1'b1;
            end else if (rx_cnt_r != {CW{1'b0}}) begin
                timer_r <= timer_r + TW'(1);
            end else begin
                timer_r <= {TW{1'b0}};
            end
        end
    end

    assign header       = header_r;
    assign header_valid = header_valid_r;
    assign frame_err    = frame_err_r;

    uart_byte_serializer #(
        .NONCE_BYTES (NONCE_BYTES)
    ) u_serializer (
        .clock     (clock),
        .reset     (reset),
        .nonce_in  (nonce_in),
        .nonce_we  (nonce_we),
        .send_req  (send_req),
        .tx_busy   (uart.tx_busy),
        .rx_active (uart.rx_active),
        .tx_data   (uart.tx_data),
        .tx_strobe (uart.tx_strobe),
        .tx_done   (tx_done),
        .tx_active (tx_active)
    );

endmodule

// File: tb/tb_uart_msg_engine.sv
// Scoreboard bench for uart_msg_engine (HDR_BYTES=4, NONCE_BYTES=4,
// TIMEOUT_CYCLES=100). Stimulus pushes expected headers, error pulses and
// tx bytes; a negedge monitor pops and compares as the DUT produces them.
// Honours UART_MSG_CHECKSUM_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_uart_msg_engine;

    localparam int HDR_BYTES      = 4;
    localparam int NONCE_BYTES    = 4;
    localparam int TIMEOUT_CYCLES = 100;
    localparam int HW = HDR_BYTES * 8;
    localparam int NW = NONCE_BYTES * 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [HW-1:0] header;
    logic          header_valid, frame_err, tx_done, tx_active;
    logic [NW-1:0] nonce_in = '0;
    logic          nonce_we = 1'b0;
    logic          send_req = 1'b0;

    uart_msg_engine_if u_if ();

    uart_msg_engine #(
        .HDR_BYTES      (HDR_BYTES),
        .NONCE_BYTES    (NONCE_BYTES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .uart         (u_if),
        .header       (header),
        .header_valid (header_valid),
        .frame_err    (frame_err),
        .nonce_in     (nonce_in),
        .nonce_we     (nonce_we),
        .send_req     (send_req),
        .tx_done      (tx_done),
        .tx_active    (tx_active)
    );

    always #10 clock = ~clock;

    int checks = 0;
    int passes = 0;

    logic [HW-1:0] hdr_q[$];
    logic [7:0]    tx_q[$];
    logic [7:0]    frame[$];
    int            err_exp   = 0;
    int            done_exp  = 0;
    int            done_seen = 0;
    bit            inflight  = 1'b0;
    logic [NW-1:0] model_nonce = '0;
    int            busy_cnt = 0;
    int            busy_len = 10;
    logic [HW-1:0] mon_h;
    logic [7:0]    mon_b;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: a frame is the list of bytes seen since the last drop or completion.
    function automatic void model_rx(input logic [7:0] b);
        logic [HW-1:0] h;
        logic [7:0]    x;
        frame.push_back(b);
        if (frame.size() == HDR_BYTES
`ifdef UART_MSG_CHECKSUM_EN
            + 1
`endif
        ) begin
            h = '0;
            x = 8'h00;
            for (int i = 0; i < HDR_BYTES; i++) begin
                h = h * 256 + HW'(frame[i]);
                x = x ^ frame[i];
            end
`ifdef UART_MSG_CHECKSUM_EN
            if (frame[HDR_BYTES] == x) hdr_q.push_back(h);
            else err_exp++;
`else
            hdr_q.push_back(h);
`endif
            frame.delete();
        end
    endfunction

    task automatic rx_byte(input logic [7:0] b);
        u_if.rx_data   = b;
        u_if.rx_strobe = 1'b1;
        model_rx(b);
        @(negedge clock);
        u_if.rx_strobe = 1'b0;
    endtask

    task automatic rx_err(input bit with_strobe);
        u_if.rx_error  = 1'b1;
        u_if.rx_strobe = with_strobe;
        u_if.rx_data   = 8'($urandom);
        frame.delete();
        err_exp++;
        @(negedge clock);
        u_if.rx_error  = 1'b0;
        u_if.rx_strobe = 1'b0;
    endtask

    task automatic idle(input int n);
        if (frame.size() != 0 && n >= TIMEOUT_CYCLES) begin
            frame.delete();
            err_exp++;
        end
        repeat (n) @(negedge clock);
    endtask

    task automatic rx_frame(input logic [HW-1:0] h, input int max_gap);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        for (int i = 0; i < HDR_BYTES; i++) begin
            b = h[(HDR_BYTES-1-i)*8 +: 8];
            x = x ^ b;
            rx_byte(b);
            repeat ($urandom_range(0, max_gap)) @(negedge clock);
        end
`ifdef UART_MSG_CHECKSUM_EN
        rx_byte(x);
`endif
    endtask

    task automatic load_nonce(input logic [NW-1:0] v);
        nonce_we    = 1'b1;
        nonce_in    = v;
        model_nonce = v;
        @(negedge clock);
        nonce_we    = 1'b0;
    endtask

    task automatic send(input bit we, input logic [NW-1:0] v);
        logic [NW-1:0] src;
        logic [7:0]    x;
        send_req = 1'b1;
        nonce_we = we;
        nonce_in = v;
        if (!inflight) begin
            src = we ? v : model_nonce;
            x   = 8'h00;
            for (int i = NONCE_BYTES - 1; i >= 0; i--) begin
                tx_q.push_back(src[i*8 +: 8]);
                x = x ^ src[i*8 +: 8];
            end
`ifdef UART_MSG_CHECKSUM_EN
            tx_q.push_back(x);
`endif
            done_exp++;
            inflight = 1'b1;
        end
        if (we) model_nonce = v;
        @(negedge clock);
        send_req = 1'b0;
        nonce_we = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int start;
        int n;
        start = done_seen;
        n = 0;
        while (done_seen == start && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(done_seen != start, "tx_done_wait", 64'(n), 64'(budget));
    endtask

    task automatic wait_tx_left(input int left, input int budget);
        int n;
        n = 0;
        while (tx_q.size() > left && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(tx_q.size() <= left, "tx_progress_wait", 64'(tx_q.size()), 64'(left));
    endtask

    // uart transmitter model: busy for busy_len cycles after each strobe.
    always @(negedge clock) begin
        if (reset) begin
            busy_cnt     = 0;
            u_if.tx_busy = 1'b0;
        end else begin
            if (u_if.tx_strobe) busy_cnt = busy_len;
            else if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
            u_if.tx_busy = (busy_cnt != 0);
        end
    end

    // Monitor: compare every DUT event against the scoreboard.
    always @(negedge clock) begin
        if (!reset) begin
            if (header_valid) begin
                if (hdr_q.size() == 0) begin
                    check(1'b0, "header_valid_unexpected", 64'(header), 64'd0);
                end else begin
                    mon_h = hdr_q.pop_front();
                    check(header === mon_h, "header_value", 64'(header), 64'(mon_h));
                end
            end
            if (frame_err) begin
                check(err_exp > 0, "frame_err_expected", 64'd1, 64'(err_exp));
                if (err_exp > 0) err_exp--;
            end
            if (u_if.tx_strobe) begin
                if (tx_q.size() == 0) begin
                    check(1'b0, "tx_strobe_unexpected", 64'(u_if.tx_data), 64'd0);
                end else begin
                    mon_b = tx_q.pop_front();
                    check(u_if.tx_data === mon_b, "tx_byte", 64'(u_if.tx_data), 64'(mon_b));
                end
                check(tx_active && !u_if.rx_active, "tx_strobe_conditions",
                      {62'd0, tx_active, u_if.rx_active}, 64'd2);
            end
            if (tx_done) begin
                check(done_exp > 0 && tx_q.size() == 0, "tx_done_expected",
                      64'(tx_q.size()), 64'd0);
                if (done_exp > 0) done_exp--;
                inflight = 1'b0;
                done_seen++;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check(header === '0,        {tag, "_header"},       64'(header), 64'd0);
        check(header_valid === 1'b0, {tag, "_header_valid"}, 64'(header_valid), 64'd0);
        check(frame_err === 1'b0,    {tag, "_frame_err"},    64'(frame_err), 64'd0);
        check(u_if.tx_data === 8'h00, {tag, "_tx_data"},     64'(u_if.tx_data), 64'd0);
        check(u_if.tx_strobe === 1'b0, {tag, "_tx_strobe"},  64'(u_if.tx_strobe), 64'd0);
        check(tx_done === 1'b0,      {tag, "_tx_done"},      64'(tx_done), 64'd0);
        check(tx_active === 1'b0,    {tag, "_tx_active"},    64'(tx_active), 64'd0);
    endtask

    initial begin
        logic [HW-1:0] h;
        int            errpos;
        u_if.rx_data   = 8'h00;
        u_if.rx_strobe = 1'b0;
        u_if.rx_error  = 1'b0;
        u_if.rx_active = 1'b0;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Basic frame, then timeout after two bytes, then a fresh frame.
        rx_frame(32'hDEADBEEF, 0);
        idle(5);
        rx_byte(8'h55);
        rx_byte(8'h66);
        idle(TIMEOUT_CYCLES + 10);
        rx_frame(32'h01020304, 3);
        idle(5);

        // Error after byte 3, error with a simultaneous strobe, then full frames.
        rx_byte(8'h11);
        rx_byte(8'h22);
        rx_byte(8'h33);
        rx_err(1'b0);
        rx_frame(32'hCAFEBABE, 2);
        rx_byte(8'h44);
        rx_err(1'b1);
        rx_frame(32'h0BADF00D, 1);
        idle(5);

`ifdef UART_MSG_CHECKSUM_EN
        rx_byte(8'hAA); rx_byte(8'hBB); rx_byte(8'hCC); rx_byte(8'hDD); rx_byte(8'h00);
        idle(3);
        rx_byte(8'hAA); rx_byte(8'hBB); rx_byte(8'hCC); rx_byte(8'hDD); rx_byte(8'h01);
        idle(3);
`endif

        // Nonce transmit; a second send_req and a nonce write mid-send.
        load_nonce(32'h12345678);
        send(1'b0, '0);
        check(tx_active === 1'b1, "tx_active_after_req", 64'(tx_active), 64'd1);
        wait_tx_left(NONCE_BYTES - 1, 200);
        send(1'b0, '0);
        load_nonce(32'hA5C3_0F96);
        wait_done(300);
        idle(3);
        send(1'b0, '0);
        wait_done(300);
        idle(3);

        // rx_active blocks the first byte until released.
        u_if.rx_active = 1'b1;
        send(1'b1, 32'h9ABCDEF0);
        repeat (20) @(negedge clock);
        check(tx_q.size() == NONCE_BYTES
`ifdef UART_MSG_CHECKSUM_EN
              + 1
`endif
              , "rx_active_holds_tx", 64'(tx_q.size()), 64'(NONCE_BYTES));
        check(tx_active === 1'b1, "tx_active_while_held", 64'(tx_active), 64'd1);
        u_if.rx_active = 1'b0;
        wait_done(300);
        idle(3);

        // Asynchronous reset in the middle of a send.
        send(1'b1, 32'h13579BDF);
        wait_tx_left(2, 200);
        #3 reset = 1'b1;
        #1 check_all_zero("midsend_reset");
        tx_q.delete();
        hdr_q.delete();
        frame.delete();
        done_exp    = 0;
        err_exp     = 0;
        inflight    = 1'b0;
        model_nonce = '0;
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        send(1'b0, '0);
        wait_done(300);

        // Randomised traffic.
        for (int it = 0; it < 25; it++) begin
            h      = HW'($urandom);
            errpos = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, HDR_BYTES - 1)) : -1;
            for (int i = 0; i < HDR_BYTES; i++) begin
                if (i == errpos) rx_err($urandom_range(0, 1) == 1);
                rx_byte(h[(HDR_BYTES-1-i)*8 +: 8]);
                repeat ($urandom_range(0, 6)) @(negedge clock);
            end
            idle(TIMEOUT_CYCLES + 10);
            busy_len = $urandom_range(2, 12);
            send($urandom_range(0, 1) == 1, NW'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 15)) @(negedge clock);
                load_nonce(NW'($urandom));
            end
            wait_done(400);
            idle($urandom_range(0, 4));
        end

        idle(10);
        check(hdr_q.size() == 0, "headers_outstanding", 64'(hdr_q.size()), 64'd0);
        check(err_exp == 0,      "frame_err_outstanding", 64'(err_exp), 64'd0);
        check(tx_q.size() == 0,  "tx_bytes_outstanding", 64'(tx_q.size()), 64'd0);
        check(done_exp == 0,     "tx_done_outstanding", 64'(done_exp), 64'd0);
        check(tx_active === 1'b0, "tx_active_idle", 64'(tx_active), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
